// File: rtl/video_stream_packer.sv
// video_stream_packer: turns a den-qualified pixel bus into a valid/ready
// pixel stream with start-of-frame (tuser) and end-of-line (tlast) markers.
// Accepted pixels pass through a one-stage hold register into a small FIFO.
// Sticky flags report FIFO overflow and line-length errors.
//
// Handshake: a beat transfers on a rising edge where m_tvalid and m_tready
// are both 1; m_tvalid never depends on m_tready, and m_tdata/m_tuser/m_tlast
// stay stable while m_tvalid is 1 and the beat has not been taken.
module video_stream_packer #(
    parameter int   H_VISIBLE  = 1920,
    parameter int   FIFO_DEPTH = 16,
    parameter logic VSYNC_POL  = 1'b1
) (
    input  logic        pixel_clock,
    input  logic        reset,
    input  logic        video_vsync,
    input  logic        video_den,
    input  logic        video_line_start,
    input  logic [23:0] video_data,
    output logic [23:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tuser,
    output logic        m_tlast,
    output logic        overflow,
    output logic        line_err,
    output logic [1:0]  fsm_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(H_VISIBLE + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] H_VIS_C = CW'(H_VISIBLE);

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        ACTIVE    = 2'd1,
        DROP      = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          vsync_q;
    logic          frame_start;
    logic          hold_valid;
    logic [23:0]   hold_data;
    logic [25:0]   mem [FIFO_DEPTH];
    logic [25:0]   head;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, pop;
    logic          accept_en, wr_en, drop_evt, line_end;
    logic          sof_armed;
    logic [CW-1:0] line_cnt, cnt_inc;
    logic          overflow_q, line_err_q;

    // Frame start is the inactive-to-active transition of vsync.
    assign frame_start = (video_vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && m_tready;

    // Saturating increment so a runaway line cannot wrap back to a legal count.
    assign cnt_inc  = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + CW'(1);
    // A push that happens while den is already low closes the line.
    assign line_end = wr_en && !video_den;

    // FSM state register.
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) state_q <= SYNC_WAIT;
        else        state_q <= state_d;
    end

    // FSM next-state: frame start wins from any state; overflow parks in DROP.
    always_comb begin
        state_d = state_q;
        if (frame_start)                      state_d = ACTIVE;
        else if (state_q == ACTIVE && drop_evt) state_d = DROP;
    end

    // FSM outputs: capture enable, FIFO write and overflow event.
    always_comb begin
        accept_en = 1'b0;
        wr_en     = 1'b0;
        drop_evt  = 1'b0;
        if (state_q == ACTIVE) begin
            accept_en = 1'b1;
            wr_en     = hold_valid && (!full || pop);
            drop_evt  = hold_valid && full && !pop;
        end
    end

    // Vsync edge register, hold stage, pointers, SOF, line counter and flags.
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            vsync_q    <= !VSYNC_POL;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            sof_armed  <= 1'b0;
            line_cnt   <= '0;
            overflow_q <= 1'b0;
            line_err_q <= 1'b0;
        end else begin
            vsync_q    <= video_vsync;
            hold_valid <= video_den && accept_en;
            if (video_den && accept_en) hold_data <= video_data;
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
            if (frame_start)  sof_armed <= 1'b1;
            else if (wr_en)   sof_armed <= 1'b0;
            if (frame_start || line_end) line_cnt <= '0;
            else if (wr_en)              line_cnt <= cnt_inc;
            if (drop_evt) overflow_q <= 1'b1;
            if ((line_end && cnt_inc != H_VIS_C) || (video_line_start && video_den))
                line_err_q <= 1'b1;
        end
    end

    // FIFO storage: {tuser, tlast, data}; no reset needed, empty masks it.
    always_ff @(posedge pixel_clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {sof_armed, !video_den, hold_data};
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign m_tvalid  = !empty;
    assign m_tdata   = empty ? 24'd0 : head[23:0];
    assign m_tlast   = !empty && head[24];
    assign m_tuser   = !empty && head[25];
    assign overflow  = overflow_q;
    assign line_err  = line_err_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_video_stream_packer.sv
// Self-checking bench for video_stream_packer (H_VISIBLE=4, FIFO_DEPTH=8).
// Drivers push the expected {tuser, tlast, data} beats into a queue; a
// negedge monitor pops and compares every beat the DUT hands over.
module tb_video_stream_packer;

  localparam int H_VIS = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        video_vsync = 1'b0;
  logic        video_den = 1'b0;
  logic        video_line_start = 1'b0;
  logic [23:0] video_data = '0;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tuser;
  logic        m_tlast;
  logic        overflow;
  logic        line_err;
  logic [1:0]  fsm_state;

  video_stream_packer #(
    .H_VISIBLE (H_VIS),
    .FIFO_DEPTH(DEPTH),
    .VSYNC_POL (1'b1)
  ) dut (
    .pixel_clock     (clk),
    .reset           (rst_n),
    .video_vsync     (video_vsync),
    .video_den       (video_den),
    .video_line_start(video_line_start),
    .video_data      (video_data),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .m_tuser         (m_tuser),
    .m_tlast         (m_tlast),
    .overflow        (overflow),
    .line_err        (line_err),
    .fsm_state       (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [25:0] exp_q[$];
  logic [25:0] mon_e;
  int total = 0;
  int bad = 0;
  int beats = 0;
  int extra_beats = 0;
  int first_den_cyc = -1;
  int first_valid_cyc = -1;
  bit sof_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_tvalid && first_valid_cyc < 0 && first_den_cyc >= 0) first_valid_cyc = cyc;
    if (m_tvalid && m_tready) begin
      beats++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("beat", {6'd0, m_tuser, m_tlast, m_tdata}, {6'd0, mon_e});
      end else begin
        extra_beats++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic vsync_rise();
    @(posedge clk); #1 video_vsync = 1'b1;
    repeat (2) @(posedge clk);
    #1 video_vsync = 1'b0;
    sof_pending = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic drive_line(input int n, input int base, input bit exp_en);
    logic [23:0] d;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      d = 24'(base + i);
      video_den  = 1'b1;
      video_data = d;
      if (first_den_cyc < 0) first_den_cyc = cyc;
      if (exp_en) begin
        exp_q.push_back({sof_pending, (i == n - 1), d});
        sof_pending = 1'b0;
      end
    end
    @(posedge clk); #1 video_den = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_tvalid) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int extra0;
    // reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tuser", 32'(m_tuser), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_line_err", 32'(line_err), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // den pixels with no vsync edge yet: all ignored
    m_tready = 1'b1;
    drive_line(H_VIS, 32'h50, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    check("nosync_extra", 32'(extra_beats), 32'd0);
    check("nosync_tvalid", 32'(m_tvalid), 32'd0);
    check("nosync_overflow", 32'(overflow), 32'd0);
    check("nosync_line_err", 32'(line_err), 32'd0);
    check("nosync_state", 32'(fsm_state), 32'd0);

    // basic frame: 2 lines, pixels 1..8, latency check
    vsync_rise();
    #2 check("sof_state", 32'(fsm_state), 32'd1);
    first_den_cyc = -1;
    first_valid_cyc = -1;
    beats = 0;
    drive_line(H_VIS, 1, 1'b1);
    drive_line(H_VIS, 5, 1'b1);
    wait_drain("basic_drain");
    check("basic_latency", 32'(first_valid_cyc - first_den_cyc), 32'd2);
    check("basic_beats", 32'(beats), 32'd8);
    check("basic_extra", 32'(extra_beats), 32'd0);
    check("basic_line_err", 32'(line_err), 32'd0);

    // full FIFO with simultaneous push and pop: no drop
    m_tready = 1'b0;
    vsync_rise();
    drive_line(H_VIS, 32'h11, 1'b1);
    drive_line(H_VIS, 32'h15, 1'b1);
    #2 check("full_tvalid", 32'(m_tvalid), 32'd1);
    fork
      drive_line(H_VIS, 32'h19, 1'b1);
      begin
        @(posedge clk);
        @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    wait_drain("pushpop_drain");
    check("pushpop_overflow", 32'(overflow), 32'd0);
    check("pushpop_extra", 32'(extra_beats), 32'd0);
    check("pushpop_state", 32'(fsm_state), 32'd1);

    // overflow: 12 pixels with ready low, only the first 8 survive
    m_tready = 1'b0;
    vsync_rise();
    drive_line(H_VIS, 32'h21, 1'b1);
    drive_line(H_VIS, 32'h25, 1'b1);
    drive_line(H_VIS, 32'h29, 1'b0);
    #2;
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_state", 32'(fsm_state), 32'd2);
    m_tready = 1'b1;
    wait_drain("ovf_drain");
    drive_line(H_VIS, 32'h2d, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    check("drop_extra", 32'(extra_beats), 32'd0);
    check("drop_tvalid", 32'(m_tvalid), 32'd0);
    vsync_rise();
    drive_line(H_VIS, 32'h31, 1'b1);
    wait_drain("ovf_next_frame");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // short line sets a sticky line error
    check("short_pre", 32'(line_err), 32'd0);
    drive_line(3, 32'h41, 1'b1);
    wait_drain("short_drain");
    check("short_line_err", 32'(line_err), 32'd1);
    drive_line(H_VIS, 32'h45, 1'b1);
    wait_drain("good_after_short");
    check("short_sticky", 32'(line_err), 32'd1);

    // reset mid-line with 5 entries queued
    m_tready = 1'b0;
    vsync_rise();
    drive_line(H_VIS, 32'h100, 1'b0);
    @(posedge clk); #1 video_den = 1'b1; video_data = 24'h105;
    @(posedge clk); #1 video_data = 24'h106;
    @(posedge clk); #1 video_data = 24'h107;
    check("pre_reset_tvalid", 32'(m_tvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_tvalid", 32'(m_tvalid), 32'd0);
    check("async_tdata", 32'(m_tdata), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    check("async_line_err", 32'(line_err), 32'd0);
    exp_q.delete();
    sof_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    extra0 = extra_beats;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 video_data = 24'(32'h108 + i);
    end
    @(posedge clk); #1 video_den = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("post_reset_extra", 32'(extra_beats - extra0), 32'd0);
    check("post_reset_tvalid", 32'(m_tvalid), 32'd0);
    check("post_reset_state", 32'(fsm_state), 32'd0);
    vsync_rise();
    drive_line(H_VIS, 32'h200, 1'b1);
    wait_drain("post_reset_frame");
    check("post_reset_line_err", 32'(line_err), 32'd0);

    // line_start pulse while den is high
    for (int i = 0; i < H_VIS; i++) begin
      @(posedge clk); #1;
      video_den = 1'b1;
      video_data = 24'(32'h300 + i);
      video_line_start = (i == 1);
      exp_q.push_back({1'b0, (i == H_VIS - 1), 24'(32'h300 + i)});
    end
    @(posedge clk); #1 video_den = 1'b0; video_line_start = 1'b0;
    wait_drain("ls_drain");
    check("ls_line_err", 32'(line_err), 32'd1);
    check("final_extra", 32'(extra_beats), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
